// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns EX/MEM memory controls into one
// req/ack bus transaction, stalls the pipeline meanwhile, and extends load data.
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 255,
  parameter int TMO_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size_in,
  input  logic        load_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_error,
  output logic [1:0]  dbg_state
);

  // Bus handshake: dmem_req rises the cycle after an aligned access is seen and
  // stays high with stable we/addr/be/wdata until the cycle dmem_ack is high
  // (single-cycle strobe) or the timeout expires; acks outside REQ are ignored.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam logic [TMO_W:0] TMO_LIMIT = (TMO_W+1)'(ACK_TIMEOUT);

  state_t       state_q, state_d;
  logic         access, aligned, is_byte, is_half;
  logic         start, ack_take, tmo;
  logic [3:0]   be_c;
  logic [31:0]  wdata_c;
  logic         we_q, load_q, uns_q;
  logic [29:0]  addr_q;
  logic [3:0]   be_q;
  logic [31:0]  wdata_q;
  logic [1:0]   size_q, lane_q;
  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W:0]   cnt_inc;
  logic         tmo_hit;
  logic [7:0]   ld_byte;
  logic [15:0]  ld_half;
  logic [31:0]  ld_ext;

  assign access  = mem_read | mem_write;
  assign is_byte = (size_in == 2'b10);
  assign is_half = (size_in == 2'b01);
  assign aligned = is_byte | (is_half & ~address[0]) |
                   (~is_byte & ~is_half & (address[1:0] == 2'b00));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    if (is_byte) begin
      be_c    = 4'b0001 << address[1:0];
      wdata_c = {4{store_data[7:0]}};
    end else if (is_half) begin
      be_c    = 4'b0011 << address[1:0];
      wdata_c = {2{store_data[15:0]}};
    end
  end

  // An ack arriving in the timeout cycle still completes the access.
  assign cnt_inc = {1'b0, cnt_q} + {{TMO_W{1'b0}}, 1'b1};
  assign tmo_hit = (cnt_inc >= TMO_LIMIT);

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    start    = 1'b0;
    ack_take = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && aligned) begin
          stall   = 1'b1;
          start   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem_ack) begin
          ack_take = 1'b1;
          state_d  = DONE;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      2'b10:   ld_ext = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      load_q     <= 1'b0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      lane_q     <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      misaligned <= (state_q == IDLE) && access && !aligned;
      load_valid <= ack_take && load_q;
      bus_error  <= tmo;
      if (start) begin
        we_q    <= mem_write;
        load_q  <= mem_read & ~mem_write;
        uns_q   <= load_unsigned;
        addr_q  <= address[31:2];
        be_q    <= be_c;
        wdata_q <= wdata_c;
        size_q  <= size_in;
        lane_q  <= address[1:0];
        cnt_q   <= '0;
      end else if (state_q == REQ && cnt_q != {TMO_W{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (ack_take && load_q) load_data <= ld_ext;
      else if (tmo)           load_data <= '0;
    end
  end

  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = dmem_req ? {addr_q, 2'b00} : 32'h0;
  assign dmem_be    = dmem_req ? be_q : 4'h0;
  assign dmem_wdata = dmem_req ? wdata_q : 32'h0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized accesses checked
// against a byte-lane arithmetic model of the memory access rules.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, load_unsigned, dmem_ack;
  logic [1:0]  size_in;
  logic [31:0] address, store_data, dmem_rdata;
  logic        dmem_req, dmem_we, stall, load_valid, misaligned, bus_error;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_be;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_ld;

  mem_access_unit #(.ACK_TIMEOUT(TMO), .TMO_W(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .size_in(size_in), .load_unsigned(load_unsigned), .address(address),
    .store_data(store_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
    .load_data(load_data), .load_valid(load_valid), .misaligned(misaligned),
    .bus_error(bus_error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drop_inputs();
    mem_read = 0; mem_write = 0; size_in = 0; load_unsigned = 0;
    address = 0; store_data = 0;
  endtask

  // One access from the IDLE cycle through DONE and back to IDLE.
  // ack_at < 0 or >= TMO means the bus never acknowledges.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] sd, input int ack_at,
                            input logic [31:0] rdata);
    int nbytes, lane, ncyc, stall_cnt;
    logic mis, is_load, acc, tmo;
    logic [3:0] e_be;
    logic [31:0] e_wd, mask, sign, v;
    nbytes  = (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
    lane    = int'(addr[1:0]);
    mis     = (lane % nbytes) != 0;
    acc     = rd | wr;
    is_load = rd & ~wr;
    tmo     = (ack_at < 0) || (ack_at >= TMO);
    e_be = 4'b0;
    e_wd = 32'h0;
    for (int n = 0; n < 4; n++) begin
      if (n >= lane && n < lane + nbytes) e_be[n] = 1'b1;
      e_wd[8*n +: 8] = sd[8*(n % nbytes) +: 8];
    end
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nbytes)) - 1);
    sign = 32'h1 << (8*nbytes - 1);
    v    = (rdata >> (8*lane)) & mask;
    if (!uns && nbytes != 4) v = (v ^ sign) - sign;

    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; size_in = sz; load_unsigned = uns;
    address = addr; store_data = sd;
    @(negedge clk);
    check_eq("idle_stall", {31'b0, stall}, {31'b0, acc && !mis});
    check_eq("idle_req", {31'b0, dmem_req}, 32'h0);
    stall_cnt = int'(stall);

    if (!acc || mis) begin
      @(posedge clk); #1; drop_inputs();
      @(negedge clk);
      check_eq("misaligned", {31'b0, misaligned}, {31'b0, acc && mis});
      check_eq("mis_req", {31'b0, dmem_req}, 32'h0);
      check_eq("mis_stall", {31'b0, stall}, 32'h0);
      return;
    end

    if (is_load && !tmo) exp_q.push_back(v);
    ncyc = tmo ? TMO : ack_at + 1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      dmem_ack   = (!tmo && k == ncyc - 1);
      dmem_rdata = dmem_ack ? rdata : $urandom;
      @(negedge clk);
      check_eq("req_held", {31'b0, dmem_req}, 32'h1);
      stall_cnt += int'(stall);
      if (k == 0) begin
        check_eq("bus_we", {31'b0, dmem_we}, {31'b0, wr});
        check_eq("bus_addr", dmem_addr, {addr[31:2], 2'b00});
        check_eq("bus_be", {28'b0, dmem_be}, {28'b0, e_be});
        if (wr) check_eq("bus_wdata", dmem_wdata, e_wd);
      end
    end
    check_eq("stall_len", stall_cnt, ncyc + 1);

    @(posedge clk); #1; dmem_ack = 0;
    @(negedge clk);
    check_eq("done_req", {31'b0, dmem_req}, 32'h0);
    check_eq("done_stall", {31'b0, stall}, 32'h0);
    check_eq("bus_error", {31'b0, bus_error}, {31'b0, tmo});
    check_eq("load_valid", {31'b0, load_valid}, {31'b0, is_load && !tmo});
    if (tmo) exp_ld = 32'h0;
    else if (is_load && exp_q.size() > 0) exp_ld = exp_q.pop_front();
    check_eq("load_data", load_data, exp_ld);

    @(posedge clk); #1; drop_inputs();
    @(negedge clk);
    check_eq("no_restart", {31'b0, dmem_req}, 32'h0);
    check_eq("lv_pulse", {31'b0, load_valid}, 32'h0);
    check_eq("be_pulse", {31'b0, bus_error}, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, {31'b0, dmem_req}, 32'h0);
    check_eq({tag, "_we"}, {31'b0, dmem_we}, 32'h0);
    check_eq({tag, "_addr"}, dmem_addr, 32'h0);
    check_eq({tag, "_be"}, {28'b0, dmem_be}, 32'h0);
    check_eq({tag, "_wdata"}, dmem_wdata, 32'h0);
    check_eq({tag, "_stall"}, {31'b0, stall}, 32'h0);
    check_eq({tag, "_ldata"}, load_data, 32'h0);
    check_eq({tag, "_lvalid"}, {31'b0, load_valid}, 32'h0);
    check_eq({tag, "_mis"}, {31'b0, misaligned}, 32'h0);
    check_eq({tag, "_berr"}, {31'b0, bus_error}, 32'h0);
  endtask

  initial begin
    reset = 1; dmem_ack = 0; dmem_rdata = 0; exp_ld = 0;
    drop_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1; reset = 0;

    // Directed cases
    run_access(1, 0, 2'b00, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    run_access(1, 0, 2'b10, 0, 32'h103, 32'h0, 1, 32'h80FFFFFF);
    run_access(1, 0, 2'b10, 1, 32'h103, 32'h0, 0, 32'h80FFFFFF);
    run_access(0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 1, 32'h0);
    run_access(1, 0, 2'b00, 0, 32'h101, 32'h0, 0, 32'h0);
    run_access(0, 1, 2'b01, 0, 32'h103, 32'h55AA, 0, 32'h0);
    run_access(1, 0, 2'b00, 0, 32'h40, 32'h0, -1, 32'h0);
    run_access(1, 1, 2'b00, 0, 32'h80, 32'hCAFEF00D, 0, 32'h12345678);
    run_access(1, 0, 2'b01, 0, 32'h202, 32'h0, TMO - 1, 32'h8001_7FFF);

    // Reset in the middle of REQ, then a stray ack
    @(posedge clk); #1;
    mem_read = 1; size_in = 2'b00; address = 32'h200;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_pre_req", {31'b0, dmem_req}, 32'h1);
    @(posedge clk); #1; reset = 1; drop_inputs();
    @(posedge clk); #1; reset = 0; dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_all_zero("rst_req");
    @(posedge clk); #1; dmem_ack = 0;
    @(negedge clk);
    check_eq("stray_ack_lv", {31'b0, load_valid}, 32'h0);
    check_eq("stray_ack_req", {31'b0, dmem_req}, 32'h0);
    exp_ld = 32'h0;
    exp_q.delete();

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      int ack_at;
      op = 2'($urandom_range(0, 3));
      ack_at = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TMO));
      run_access(op[0], op[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, ack_at, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the registered memory-control bits, ALU address and store data into a req/ack transaction on the data-memory bus.
- Stalls the pipeline while a transaction is outstanding.
- Returns an aligned, sign/zero-extended load result for the MEM/WB register.

Parameters:
ACK_TIMEOUT, 255, max cycles in REQ waiting for dmem_ack before abort (1..65535)
TMO_W, 16, timeout counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
mem_read  in  1  load request (from EX/MEM)
mem_write  in  1  store request (from EX/MEM)
size_in  in  2  00 word, 01 halfword, 10 byte, 11 treated as word
load_unsigned  in  1  1 = zero-extend sub-word load, 0 = sign-extend
address  in  32  byte address (EX/MEM ALU result)
store_data  in  32  store source, data in low bits
dmem_req  out  1  bus request, held until ack or timeout
dmem_we  out  1  1 = write cycle
dmem_addr  out  32  word-aligned address ({address[31:2],2'b00})
dmem_be  out  4  byte enables, bit n = bits[8n+7:8n]
dmem_wdata  out  32  lane-replicated store data
dmem_rdata  in  32  read data, valid with dmem_ack
dmem_ack  in  1  single-cycle completion strobe
stall  out  1  hold IF/ID/EX/EX-MEM registers
load_data  out  32  extended load result
load_valid  out  1  one-cycle pulse, load_data valid
misaligned  out  1  one-cycle pulse, access rejected
bus_error  out  1  one-cycle pulse, ack timeout

Behaviour:
- Reset:
  - state = IDLE, timeout counter = 0.
  - All outputs 0 (dmem_*, stall, load_data, load_valid, misaligned, bus_error).
  - Reset during REQ drops dmem_req at that edge; a late ack is ignored.
- Endianness is little-endian: byte lane = address[1:0].
- Misalignment rules:
  - Half requires address[0]=0.
  - Word requires address[1:0]=0.
  - Byte is never misaligned.
- Byte enables:
  - Byte: 0001<<a[1:0].
  - Half: 0011<<a[1:0].
  - Word: 1111.
- Write data:
  - Byte: {4{store_data[7:0]}}.
  - Half: {2{store_data[15:0]}}.
  - Word: as-is.
- Load extraction:
  - Select the lane from dmem_rdata.
  - Extend per load_unsigned to 32 bits.
- Access start condition: access = mem_read|mem_write. Both high is treated as a store, with no load_valid.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - access & aligned:
    - stall=1 combinationally in the same cycle.
    - Latch we/addr/be/wdata/size/unsigned/lane.
    - Next state REQ.
  - access & misaligned:
    - Registered misaligned pulse next cycle.
    - No bus cycle; stall=0; stay IDLE.
  - dmem_ack in IDLE is ignored.
- REQ:
  - dmem_req=1; stall=1; bus outputs stable from latched values.
  - Counter increments each cycle.
  - On dmem_ack:
    - If the access is a load, register the extended load_data.
    - Go to DONE.
  - Timeout: counter reaches ACK_TIMEOUT without ack:
    - dmem_req drops.
    - Registered bus_error pulse.
    - load_data=0.
    - Go to DONE.
  - An ack in the same cycle as timeout wins: the access completes normally.
- DONE:
  - stall=0, so the EX/MEM register advances at this edge.
  - load_valid=1 for this single cycle if the access was a load and did not time out.
  - The unchanged inputs in DONE must not restart an access.
  - Next state is always IDLE.
- Latency:
  - Request asserted the cycle after the access appears.
  - load_valid is asserted 1 cycle after ack.
  - Total stall = ack wait + 1 cycle.
- Counter:
  - Clears on entry to REQ.
  - Saturates; never wraps.
- load_data holds its last value except on update or timeout.

Test Plan:
- LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF:
  - dmem_addr=0x100, be=1111, we=0, stall high 4 cycles.
  - load_valid pulse with load_data=0xDEADBEEF.
- LB signed addr 0x103, rdata 0x80FFFFFF -> be=1000, load_data=0xFFFFFF80. Same access with LBU -> 0x00000080.
- SH addr 0x102, store_data 0x1234ABCD:
  - Bus: we=1, be=1100, wdata=0xABCDABCD, dmem_addr=0x100.
  - Completion: no load_valid.
- LW addr 0x101 -> misaligned pulse once, dmem_req never asserted, stall 0. SH at 0x103 gives the same result.
- ACK_TIMEOUT=4, no ack:
  - dmem_req high 4 cycles, then bus_error pulse.
  - stall released after DONE; load_valid stays 0.
- Reset asserted in REQ:
  - Next cycle all outputs 0, state IDLE.
  - A subsequent stray ack produces no load_valid.
